// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART transmit byte stream between two
// requesters: tags each packet with its channel, pulls bytes one at a time, aborts on stall.
module uart_tx_arbiter #(
  parameter logic [7:0]  TAG_BASE = 8'hA0,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_i,
  input  logic       req1_i,
  output logic       readclk0_o,
  output logic       readclk1_o,
  input  logic       inclk0_i,
  input  logic       inclk1_i,
  input  logic [7:0] in0_i,
  input  logic [7:0] in1_i,
  input  logic       last0_i,
  input  logic       last1_i,
  input  logic       downstream_rdy_i,
  output logic [7:0] out_o,
  output logic       outclk_o,
  output logic       busy_o,
  output logic       grant_o,
  output logic       err_o
);

  localparam int CW = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_TAG, S_REQ, S_WAIT} state_e;

  state_e        state_q, state_d;
  logic          grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    out_q, out_d;
  logic          outclk_q, outclk_d;
  logic          readclk0_q, readclk0_d;
  logic          readclk1_q, readclk1_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  // Only the granted channel's strobe, data and last flag are ever looked at.
  logic       selInclk;
  logic       selLast;
  logic [7:0] selData;

  assign selInclk = grant_q ? inclk1_i : inclk0_i;
  assign selLast  = grant_q ? last1_i  : last0_i;
  assign selData  = grant_q ? in1_i    : in0_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      grant_q    <= 1'b1;
      cnt_q      <= '0;
      out_q      <= 8'h00;
      outclk_q   <= 1'b0;
      readclk0_q <= 1'b0;
      readclk1_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      outclk_q   <= outclk_d;
      readclk0_q <= readclk0_d;
      readclk1_q <= readclk1_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          grant_d = (req0_i && req1_i) ? ~grant_q : req1_i;
          state_d = S_TAG;
        end
      end
      S_TAG: begin
        if (downstream_rdy_i) state_d = S_REQ;
      end
      S_REQ: begin
        if (downstream_rdy_i) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A byte arriving on the final allowed cycle still wins over the abort.
        if (selInclk) begin
          state_d = selLast ? S_IDLE : S_REQ;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    out_d      = out_q;
    outclk_d   = 1'b0;
    readclk0_d = 1'b0;
    readclk1_d = 1'b0;
    err_d      = 1'b0;
    busy_d     = (state_d != S_IDLE);
    unique case (state_q)
      S_TAG: begin
        if (downstream_rdy_i) begin
          outclk_d = 1'b1;
          out_d    = {TAG_BASE[7:1], grant_q};
        end
      end
      S_REQ: begin
        if (downstream_rdy_i) begin
          readclk0_d = ~grant_q;
          readclk1_d = grant_q;
        end
      end
      S_WAIT: begin
        // No ready check here: the slot was reserved when the read was issued.
        if (selInclk) begin
          outclk_d = 1'b1;
          out_d    = selData;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_o      = out_q;
  assign outclk_o   = outclk_q;
  assign readclk0_o = readclk0_q;
  assign readclk1_o = readclk1_q;
  assign busy_o     = busy_q;
  assign grant_o    = grant_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a cycle-exact vector table for a single packet,
// then requester models driving tie, back-pressure, timeout, spurious-strobe and reset cases.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       readclk0, readclk1;
  logic       inclk0 = 1'b0, inclk1 = 1'b0;
  logic [7:0] in0 = 8'h00, in1 = 8'h00;
  logic       last0 = 1'b0, last1 = 1'b0;
  logic       rdy = 1'b1;
  logic [7:0] out;
  logic       outclk, busy, grant, err;

  uart_tx_arbiter #(.TAG_BASE(8'hA0), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .readclk0_o(readclk0), .readclk1_o(readclk1),
    .inclk0_i(inclk0), .inclk1_i(inclk1),
    .in0_i(in0), .in1_i(in1),
    .last0_i(last0), .last1_i(last1),
    .downstream_rdy_i(rdy),
    .out_o(out), .outclk_o(outclk), .busy_o(busy), .grant_o(grant), .err_o(err)
  );

  always #10 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Requester model and monitor state
  int pkts0, pkts1, pend0, pend1, lat, cyc;
  logic dec0, dec1, respOn0, respOn1, spur0, spur1;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] got[$];
  int outclkCnt = 0, rcCnt = 0, errCount = 0, invBad = 0;
  int rc0Cyc, rc1Cyc, errCyc;

  typedef struct packed {
    logic       req0;
    logic       inclk0;
    logic [7:0] in0;
    logic       last0;
    logic       eOutclk;
    logic [7:0] eOut;
    logic       eRc0;
    logic       eBusy;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; inclk0 = 1'b0; inclk1 = 1'b0;
    in0 = 8'h00; in1 = 8'h00; last0 = 1'b0; last1 = 1'b0; rdy = 1'b1;
    pkts0 = 0; pkts1 = 0; pend0 = 0; pend1 = 0; dec0 = 1'b0; dec1 = 1'b0;
    q0.delete(); q1.delete(); got.delete();
    spur0 = 1'b0; spur1 = 1'b0; respOn0 = 1'b1; respOn1 = 1'b1; lat = 1;
    rc0Cyc = -1; rc1Cyc = -1; errCyc = -1; errCount = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One table row: drive at the falling edge, compare just after the next rising edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    req0 = v.req0; req1 = 1'b0; inclk0 = v.inclk0; in0 = v.in0; last0 = v.last0;
    inclk1 = 1'b0; rdy = 1'b1;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d", idx),
                64'({outclk, out, readclk0, readclk1, busy, err, grant}),
                64'({v.eOutclk, v.eOut, v.eRc0, 1'b0, v.eBusy, 1'b0, 1'b0}));
  endtask

  // One clock of the requester models plus output monitoring.
  task automatic stepCycle();
    @(negedge clk);
    if (dec0) begin pkts0--; dec0 = 1'b0; end
    if (dec1) begin pkts1--; dec1 = 1'b0; end
    req0 = (pkts0 > 0);
    req1 = (pkts1 > 0);
    inclk0 = 1'b0; inclk1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
    if (pend0 > 0) begin
      pend0--;
      if (pend0 == 0 && respOn0 && q0.size() > 0) begin
        {last0, in0} = q0.pop_front();
        inclk0 = 1'b1;
        if (last0) dec0 = 1'b1;
      end
    end
    if (pend1 > 0) begin
      pend1--;
      if (pend1 == 0 && respOn1 && q1.size() > 0) begin
        {last1, in1} = q1.pop_front();
        inclk1 = 1'b1;
        if (last1) dec1 = 1'b1;
      end
    end
    if (spur0 && !inclk0) begin inclk0 = 1'b1; in0 = 8'hEE; last0 = 1'b1; end
    if (spur1 && !inclk1) begin inclk1 = 1'b1; in1 = 8'hEE; last1 = 1'b1; end
    @(posedge clk);
    #1;
    cyc++;
    if (readclk0) begin pend0 = lat + 1; rc0Cyc = cyc; end
    if (readclk1) begin pend1 = lat + 1; rc1Cyc = cyc; end
    if (readclk0 || readclk1) rcCnt++;
    if (outclk) begin got.push_back(out); outclkCnt++; end
    if (err) begin errCount++; errCyc = cyc; end
    if ((readclk0 && readclk1) || (err && outclk)) invBad++;
  endtask

  task automatic runUntilDone(input string name, input int budget);
    int b = 0;
    do begin
      stepCycle();
      b++;
    end while ((busy || pkts0 > 0 || pkts1 > 0) && b < budget);
    checkOutput({name, " done"}, 64'(busy || pkts0 > 0 || pkts1 > 0), 64'(0));
  endtask

  task automatic checkStream(input string name, input int n, input logic [63:0] expBytes);
    checkOutput({name, " len"}, 64'(got.size()), 64'(n));
    for (int k = 0; k < n && k < got.size(); k++)
      checkOutput($sformatf("%s[%0d]", name, k), 64'(got[k]), 64'(expBytes[8*(n-1-k) +: 8]));
    got.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b, oc, rc;
    cyc = 0;
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA0, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0};

    doReset();
    checkOutput("reset state", 64'({outclk, out, readclk0, readclk1, busy, err, grant}),
                64'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));

    // Single ch0 packet 11/22/33 with one-cycle requester latency
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i], i);

    // Simultaneous requests: ch0 wins the first tie, then alternation
    doReset();
    pkts0 = 1; pkts1 = 1;
    q0.push_back({1'b1, 8'h55}); q1.push_back({1'b1, 8'h66});
    runUntilDone("tie1", 100);
    checkStream("tie1", 4, {8'hA0, 8'h55, 8'hA1, 8'h66});
    pkts0 = 1; pkts1 = 1;
    q0.push_back({1'b1, 8'h77}); q1.push_back({1'b1, 8'h88});
    runUntilDone("tie2", 100);
    checkStream("tie2", 4, {8'hA0, 8'h77, 8'hA1, 8'h88});

    // Back-pressure held for 20 cycles in TAG and again in REQ
    doReset();
    rdy = 1'b0;
    pkts0 = 1;
    q0.push_back({1'b0, 8'h01}); q0.push_back({1'b1, 8'h02});
    stepCycle();
    oc = outclkCnt; rc = rcCnt;
    repeat (20) stepCycle();
    checkOutput("rdy low in TAG strobes", 64'({outclkCnt - oc, rcCnt - rc}), 64'(0));
    rdy = 1'b1;
    stepCycle();
    rdy = 1'b0;
    oc = outclkCnt; rc = rcCnt;
    repeat (20) stepCycle();
    checkOutput("rdy low in REQ strobes", 64'({outclkCnt - oc, rcCnt - rc}), 64'(0));
    rdy = 1'b1;
    runUntilDone("backpressure", 100);
    checkStream("backpressure", 3, {8'hA0, 8'h01, 8'h02});

    // ch1 never answers: abort after TIMEOUT WAIT cycles, then pending ch0 is served
    doReset();
    respOn1 = 1'b0;
    pkts1 = 1;
    b = 0;
    while (rc1Cyc < 0 && b < 20) begin stepCycle(); b++; end
    checkOutput("timeout readclk1 seen", 64'(rc1Cyc >= 0), 64'(1));
    pkts0 = 1;
    q0.push_back({1'b1, 8'h99});
    b = 0;
    while (errCount == 0 && b < 30) begin stepCycle(); b++; end
    checkOutput("timeout err delay", 64'(errCyc - rc1Cyc), 64'(8));
    checkOutput("timeout busy after err", 64'(busy), 64'(0));
    pkts1 = 0;
    spur1 = 1'b1;
    stepCycle();
    spur1 = 1'b0;
    runUntilDone("timeout", 100);
    checkOutput("timeout err count", 64'(errCount), 64'(1));
    checkStream("timeout", 3, {8'hA1, 8'hA0, 8'h99});

    // Spurious ch0 strobes throughout a ch1 packet
    doReset();
    lat = 2;
    pkts1 = 1;
    q1.push_back({1'b0, 8'h31}); q1.push_back({1'b0, 8'h32}); q1.push_back({1'b1, 8'h33});
    spur0 = 1'b1;
    runUntilDone("spurious", 100);
    spur0 = 1'b0;
    checkStream("spurious", 4, {8'hA1, 8'h31, 8'h32, 8'h33});

    // Reset while waiting for a byte that then arrives one cycle later
    doReset();
    respOn0 = 1'b0;
    pkts0 = 1;
    b = 0;
    while (rc0Cyc < 0 && b < 20) begin stepCycle(); b++; end
    checkOutput("rstwait readclk0 seen", 64'(rc0Cyc >= 0), 64'(1));
    rst = 1'b1;
    stepCycle();
    checkOutput("rstwait outputs", 64'({outclk, out, readclk0, readclk1, busy, err, grant}),
                64'({1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    got.delete();
    rst = 1'b0;
    pend0 = 0;
    spur0 = 1'b1;
    stepCycle();
    spur0 = 1'b0;
    checkOutput("rstwait late byte", 64'({outclk, readclk0}), 64'(0));
    respOn0 = 1'b1;
    q0.push_back({1'b1, 8'h46});
    runUntilDone("rstwait", 100);
    checkStream("rstwait", 2, {8'hA0, 8'h46});

    checkOutput("invariants", 64'(invBad), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
